// File: rtl/ram_operand_seq.sv
// rtl/ram_operand_seq.sv - moves whole 256-bit operands in/out of an 8x32 word RAM
// Word k of the operand lives at RAM address k (address 0 = least-significant word).
`timescale 1ns/1ps
module ram_operand_seq #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     op,
    input  logic [WORD_W*WORDS-1:0]  wr_data,
    output logic [WORD_W*WORDS-1:0]  rd_data,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic                     ram_we,
    output logic [WORD_W-1:0]        ram_din,
    input  logic [WORD_W-1:0]        ram_dout
);

    localparam int OP_W = WORD_W * WORDS;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR       = 3'd1;
    localparam logic [2:0] S_RD       = 3'd2;
    localparam logic [2:0] S_RD_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [OP_W-1:0]   wr_buf_q, wr_buf_d;
    logic [OP_W-1:0]   rd_data_q, rd_data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] din_q, din_d;
    logic              cap_en_q, cap_en_d;
    logic [ADDR_W-1:0] cap_idx_q, cap_idx_d;
    logic [ADDR_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_buf_d  = wr_buf_q;
        rd_data_d = rd_data_q;
        addr_d    = addr_q;
        we_d      = 1'b0;
        din_d     = '0;
        cap_en_d  = 1'b0;
        cap_idx_d = cnt_q;

        // RAM output is registered, so each read word is captured one cycle after its address
        if (cap_en_q) begin
            rd_data_d[cap_idx_q*WORD_W +: WORD_W] = ram_dout;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                if (start) begin
                    wr_buf_d = wr_data;
                    addr_d   = '0;
                    if (op) begin
                        state_d = S_WR;
                        we_d    = 1'b1;
                        din_d   = wr_data[WORD_W-1:0];
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_WR: begin
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_inc;
                    addr_d = cnt_inc;
                    we_d   = 1'b1;
                    din_d  = wr_buf_q[cnt_inc*WORD_W +: WORD_W];
                end
            end
            S_RD: begin
                cap_en_d  = 1'b1;
                cap_idx_d = cnt_q;
                if (cnt_q == LAST) begin
                    state_d = S_RD_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_inc;
                    addr_d = cnt_inc;
                end
            end
            S_RD_DRAIN: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_buf_q  <= '0;
            rd_data_q <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            din_q     <= '0;
            cap_en_q  <= 1'b0;
            cap_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_buf_q  <= wr_buf_d;
            rd_data_q <= rd_data_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            din_q     <= din_d;
            cap_en_q  <= cap_en_d;
            cap_idx_q <= cap_idx_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign ram_addr = addr_q;
    assign ram_we   = we_q;
    assign ram_din  = din_q;
    assign busy     = (state_q == S_WR) || (state_q == S_RD) || (state_q == S_RD_DRAIN);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_ram_operand_seq.sv
// tb/tb_ram_operand_seq.sv - scoreboard bench for ram_operand_seq with a behavioural RAM
`timescale 1ns/1ps
module tb_ram_operand_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op;
    logic [255:0] wr_data;
    logic [255:0] rd_data;
    logic         busy;
    logic         done;
    logic [2:0]   ram_addr;
    logic         ram_we;
    logic [31:0]  ram_din;
    logic [31:0]  ram_dout;

    ram_operand_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    // RAM with registered read port
    logic [31:0]  mem [8];
    logic         preload_en = 1'b0;
    logic [255:0] preload_data = '0;
    always @(posedge clk) begin
        if (preload_en) begin
            for (int k = 0; k < 8; k++) mem[k] <= preload_data[32*k +: 32];
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit           is_rd;
        logic [255:0] data;
        int           cyc;
    } done_t;
    typedef struct {
        logic [2:0]  a;
        logic [31:0] d;
    } wr_t;

    done_t        exp_done [$];
    wr_t          exp_wr [$];
    logic [31:0]  model_mem [8];
    logic [255:0] rd_hold = '0;
    int           checks = 0;
    int           failures = 0;
    bit           mon_en = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] model_op();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = model_mem[k];
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // nwr < 8 models an aborted write: only the first nwr words land and no done follows
    task automatic push_op(input bit o, input logic [255:0] d, input int nwr, input int c0);
        done_t e;
        wr_t   w;
        if (o) begin
            for (int k = 0; k < nwr; k++) begin
                w.a = 3'(k);
                w.d = d[32*k +: 32];
                exp_wr.push_back(w);
                model_mem[k] = d[32*k +: 32];
            end
            if (nwr == 8) begin
                e.is_rd = 1'b0;
                e.data  = rd_hold;
                e.cyc   = c0 + 9;
                exp_done.push_back(e);
            end
        end else begin
            rd_hold = model_op();
            e.is_rd = 1'b1;
            e.data  = rd_hold;
            e.cyc   = c0 + 10;
            exp_done.push_back(e);
        end
    endtask

    // Called just after a negedge; returns at the negedge of cycle 1
    task automatic issue(input bit o, input logic [255:0] d, input int nwr);
        start   = 1'b1;
        op      = o;
        wr_data = d;
        push_op(o, d, nwr, cyc);
        @(negedge clk);
        start   = 1'b0;
        op      = 1'($urandom);
        wr_data = rand256();
    endtask

    always @(negedge clk) begin : monitor
        wr_t   w;
        done_t e;
        if (mon_en) begin
            if (ram_we === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=addr%0d expected=no_strobe", ram_addr);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", 256'(ram_addr), 256'(w.a));
                    chk("wr_din", 256'(ram_din), 256'(w.d));
                end
            end else begin
                chk("din_zero_no_we", 256'(ram_din), 256'd0);
            end
            if (done === 1'b1) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=cycle%0d expected=no_done", cyc);
                end else begin
                    e = exp_done.pop_front();
                    chk("done_cycle", 256'(cyc), 256'(e.cyc));
                    chk("busy_at_done", 256'(busy), 256'd0);
                    chk(e.is_rd ? "rd_data" : "rd_data_hold", rd_data, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d;
        int           c0;
        bit           o;

        rst = 1'b1; start = 1'b0; op = 1'b0; wr_data = '0;
        for (int k = 0; k < 8; k++) model_mem[k] = '0;
        preload_data = '0;
        preload_en   = 1'b1;
        repeat (3) @(negedge clk);
        preload_en = 1'b0;
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_done", 256'(done), 256'd0);
        chk("rst_we", 256'(ram_we), 256'd0);
        chk("rst_addr", 256'(ram_addr), 256'd0);
        chk("rst_din", 256'(ram_din), 256'd0);
        chk("rst_rd_data", rd_data, 256'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // known-vector write then read-back with busy profile
        issue(1'b1, 256'h47a2dcf8_7221ed74_a10df3da_be87133f_f4091278_764d0426_e024c340_6a3ca057, 8);
        repeat (9) @(negedge clk);
        issue(1'b0, '0, 8);
        chk("rd_busy_c1", 256'(busy), 256'd1);
        for (int i = 2; i <= 10; i++) begin
            @(negedge clk);
            chk("rd_busy_profile", 256'(busy), 256'(i <= 9));
        end
        @(negedge clk);

        // preloaded RAM contents
        preload_data = 256'h4fe342e2_fe1a7f9b_8ee7eb4a_7c0f9e16_2bce3357_6b315ece_cbb64068_37bf51f5;
        for (int k = 0; k < 8; k++) model_mem[k] = preload_data[32*k +: 32];
        preload_en = 1'b1;
        @(negedge clk);
        preload_en = 1'b0;
        issue(1'b0, '0, 8);
        repeat (10) @(negedge clk);

        // start with op=1 in cycle 4 of a READ is ignored
        issue(1'b0, '0, 8);
        repeat (3) @(negedge clk);
        start = 1'b1; op = 1'b1; wr_data = rand256();
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);

        // start held through DONE of a WRITE starts a READ with no idle gap
        d = rand256();
        c0 = cyc;
        start = 1'b1; op = 1'b1; wr_data = d;
        push_op(1'b1, d, 8, c0);
        @(negedge clk);
        op = 1'b0; wr_data = rand256();
        push_op(1'b0, '0, 8, c0 + 9);
        repeat (9) @(negedge clk);
        start = 1'b0;
        chk("b2b_addr0", 256'(ram_addr), 256'd0);
        chk("b2b_busy", 256'(busy), 256'd1);
        repeat (11) @(negedge clk);

        // reset effective from cycle 4 of a WRITE: words 0..2 land, no done
        issue(1'b1, rand256(), 3);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd_hold = '0;
        chk("abort_busy", 256'(busy), 256'd0);
        chk("abort_we", 256'(ram_we), 256'd0);
        chk("abort_done", 256'(done), 256'd0);
        chk("abort_rd_clear", rd_data, 256'd0);
        @(negedge clk);
        issue(1'b0, '0, 8);
        repeat (10) @(negedge clk);
        issue(1'b1, rand256(), 8);
        repeat (9) @(negedge clk);
        issue(1'b0, '0, 8);
        repeat (10) @(negedge clk);

        // randomized mix of operations
        for (int i = 0; i < 10; i++) begin
            o = 1'($urandom_range(0, 1));
            issue(o, rand256(), 8);
            repeat (o ? 8 : 9) @(negedge clk);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("wr_queue_empty", 256'(exp_wr.size()), 256'd0);
        chk("done_queue_empty", 256'(exp_done.size()), 256'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
